// File: rtl/tawas_dmem.sv
// Local data memory for the tawas data port: byte lanes, 1-cycle reads, zero-fill on reset.
// Optional per-byte even parity is enabled with `define TAWAS_DMEM_PARITY_EN.

module tawas_dmem_lane #(
  parameter int ADDR_W = 12
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [7:0]        wdata_i,
  output logic [7:0]        rdata_o,
  output logic              perr_o
);
`ifdef TAWAS_DMEM_PARITY_EN
  // bit 8 holds even parity; a clean byte xors to 0 across all nine bits
  logic [8:0] mem_q [2**ADDR_W];
  always_ff @(posedge clk_i)
    if (we_i) mem_q[addr_i] <= {^wdata_i, wdata_i};
  assign rdata_o = mem_q[addr_i][7:0];
  assign perr_o  = ^mem_q[addr_i];
`else
  logic [7:0] mem_q [2**ADDR_W];
  always_ff @(posedge clk_i)
    if (we_i) mem_q[addr_i] <= wdata_i;
  assign rdata_o = mem_q[addr_i];
  assign perr_o  = 1'b0;
`endif
endmodule

module tawas_dmem #(
  parameter int          ADDR_W    = 12,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] daddr_i,
  input  logic        dcs_i,
  input  logic        dwr_i,
  input  logic [3:0]  dmask_i,
  input  logic [31:0] dout_i,
  output logic [31:0] din_o,
  output logic        core_rst_n_o,
  output logic        init_done_o,
  output logic        err_o,
  output logic [31:0] err_addr_o,
  output logic        perr_o
);
  localparam int NUM_LANES = 4;
  localparam int HI = ADDR_W + 2;

  typedef enum logic {S_INIT, S_RUN} state_e;

  state_e                         state_q, state_d;
  logic [ADDR_W-1:0]              cnt_q, cnt_d;
  logic                           core_rst_n_q;
  logic [31:0]                    din_q, err_addr_q;
  logic                           err_q, perr_q;

  logic                           run, hit, rd_hit, wr_hit, miss;
  logic [ADDR_W-1:0]              mem_addr;
  logic [NUM_LANES-1:0]           mem_we, lane_perr;
  logic [NUM_LANES-1:0][7:0]      mem_wdata, mem_rdata;
  logic                           unused_low_addr;

  assign unused_low_addr = ^daddr_i[1:0];

  assign run    = (state_q == S_RUN);
  assign hit    = (daddr_i[31:HI] == BASE_ADDR[31:HI]);
  assign rd_hit = run & dcs_i & ~dwr_i & hit;
  assign wr_hit = run & dcs_i &  dwr_i & hit;
  assign miss   = run & dcs_i & ~hit;

  // the fill counter owns the memory port until the core is let out of reset
  assign mem_addr  = run ? daddr_i[HI-1:2] : cnt_q;
  assign mem_we    = run ? (dmask_i & {NUM_LANES{wr_hit}}) : {NUM_LANES{1'b1}};
  assign mem_wdata = run ? dout_i : '0;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    tawas_dmem_lane #(.ADDR_W(ADDR_W)) u_lane (
      .clk_i   (clk_i),
      .we_i    (mem_we[g]),
      .addr_i  (mem_addr),
      .wdata_i (mem_wdata[g]),
      .rdata_o (mem_rdata[g]),
      .perr_o  (lane_perr[g])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = S_RUN;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= S_INIT;
      cnt_q        <= '0;
      core_rst_n_q <= 1'b0;
      din_q        <= '0;
      err_q        <= 1'b0;
      err_addr_q   <= '0;
      perr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      core_rst_n_q <= run;
      din_q        <= rd_hit ? mem_rdata : '0;
      perr_q       <= perr_q | (rd_hit & |lane_perr);
      if (miss) begin
        err_q <= 1'b1;
        if (!err_q) err_addr_q <= daddr_i;
      end
    end
  end

  assign din_o        = din_q;
  assign core_rst_n_o = core_rst_n_q;
  assign init_done_o  = run;
  assign err_o        = err_q;
  assign err_addr_o   = err_addr_q;
`ifdef TAWAS_DMEM_PARITY_EN
  assign perr_o       = perr_q;
`else
  assign perr_o       = 1'b0;
`endif
endmodule
